matrix_multiplication: RTL and testbench
========================================

Name: matrix_multiplication

Overview:
Sequential 2x2 integer matrix multiplier: C = A x B.
- A and B elements are unsigned 4-bit, packed in 16-bit operand buses.
- C elements are unsigned 8-bit, packed in a 32-bit result bus.
- One shared multiply-accumulate datapath is driven by an FSM.
- Each product takes a fixed 11-cycle latency.
- A running 8-bit counter reports how many multiplications have completed.

Parameters:
none (element width 4, result element width 8, dimension 2 are fixed constants in the shared package)

Ports:
clock  input  1  single system clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state
matrix_A  input  16  operand A; element A[i][j] at bits [(2i+j)*4 +: 4]
matrix_B  input  16  operand B; same packing as A
start  input  1  request a multiplication; sampled only in IDLE
matrix_result  output  32  result C; element C[i][j] at bits [(2i+j)*8 +: 8]
matrix_count  output  8  number of completed multiplications

Behaviour:
- Reset is synchronous and active-high; one clock, named clock.
- On reset: state=IDLE; matrix_result=0; matrix_count=0; operand and accumulator registers=0.
- Reset has priority over all other activity. Reset mid-operation aborts: no result update, no count increment.
- State sequence: IDLE -> LOAD -> MAC (8 steps) -> STORE -> DONE -> IDLE.
- IDLE: on an edge with start=1, go to LOAD. Otherwise hold.
- LOAD (1 cycle): latch matrix_A and matrix_B into internal operand registers. Clear the 4 internal accumulators and the step index. Go to MAC.
  - Operand inputs may change after LOAD without effect.
- MAC (8 cycles, step k=0..7): element e=k>>1 (i=e>>1, j=e&1), term t=k&1.
  - acc[e] += A[i][t] * B[t][j].
  - 4x4 -> 8-bit product; 8-bit accumulate; truncate modulo 256 on overflow.
  - After k=7, go to STORE.
- STORE (1 cycle): pack the accumulators into the internal result register. Go to DONE.
- DONE (1 cycle): copy to matrix_result; matrix_count <= matrix_count+1 (wraps 255->0). Go to IDLE.
- Latency: if start is sampled at edge 0, matrix_result and matrix_count update at edge 11.
- matrix_result holds its previous value throughout the computation (no intermediate values visible).
- start while not IDLE is ignored. start held high across several cycles launches only one operation.
- start held high in the same cycle DONE returns to IDLE launches the next operation on the following edge (back-to-back allowed).
- Overflow example: all elements 15 gives 450 per element; the required output element is 0xC2.

Decomposition:
- Package matrix_mult_pkg:
  - ELEM_W=4, RES_W=8, DIM=2, MAC_STEPS=8.
  - State enum {IDLE, LOAD, MAC, STORE, DONE}.
  - Functions to extract element (i,j) from packed operand/result buses.
- One sub-module, matrix_mac_unit: combinational 4x4 multiply plus 8-bit modulo accumulate (acc_in, a, b -> acc_out).
- FSM, operand registers, accumulators and counter live in the top.

Test Plan:
1. Reset held 1 cycle -> matrix_result=0x00000000, matrix_count=0.
2. A=0x4321, B=0x1234, start 1 cycle -> 11 edges later matrix_result=0x0D140508 (C=[8,5;20,13]), matrix_count=1.
   - Result unchanged (0) on edges 1-10.
3. After idle: A=0x6543, B=0xA987, start held 2 cycles -> result=0x64594039 (C=[57,64;89,100]), count=2.
   - Only one operation runs; no third increment.
4. A=B=0xFFFF -> every element 0xC2, result=0xC2C2C2C2 (modulo truncation).
5. Start an operation, assert reset at edge 5 -> result=0, count=0, state IDLE. A subsequent start completes normally after 11 edges.
6. 256 back-to-back operations -> matrix_count wraps to 0. Pulsing start during MAC has no effect on latency or count.

Source files
------------

// File: rtl/matrix_mult_pkg.sv
// Shared constants, FSM state type and packed-bus element helpers for the
// 2x2 matrix multiplier.
package matrix_mult_pkg;

  localparam int ELEM_W    = 4;
  localparam int RES_W     = 8;
  localparam int DIM       = 2;
  localparam int MAC_STEPS = 8;
  localparam int OP_W      = DIM * DIM * ELEM_W;
  localparam int RES_BUS_W = DIM * DIM * RES_W;
  localparam int STEP_W    = $clog2(MAC_STEPS);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC,
    STORE,
    DONE
  } state_e;

  // Element (i,j) sits at flat index 2i+j.
  function automatic logic [ELEM_W-1:0] get_op_elem(input logic [OP_W-1:0] bus,
                                                     input logic i, input logic j);
    logic [1:0] e;
    e = {i, j};
    return bus[e*ELEM_W +: ELEM_W];
  endfunction

  function automatic logic [RES_W-1:0] get_res_elem(input logic [RES_BUS_W-1:0] bus,
                                                     input logic i, input logic j);
    logic [1:0] e;
    e = {i, j};
    return bus[e*RES_W +: RES_W];
  endfunction

endpackage

// File: rtl/matrix_mac_unit.sv
// Combinational 4x4 multiply feeding an 8-bit accumulate; both wrap modulo 256.
module matrix_mac_unit
  import matrix_mult_pkg::*;
(
  input  logic [RES_W-1:0]  acc_in,
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  output logic [RES_W-1:0]  acc_out
);

  logic [RES_W-1:0] prod;

  assign prod    = RES_W'(a) * RES_W'(b);
  assign acc_out = acc_in + prod;

endmodule

// File: rtl/matrix_multiplication.sv
// Sequential 2x2 matrix multiplier: one shared MAC walks 8 steps, the result
// is published and the completion counter bumped 11 edges after start.
module matrix_multiplication
  import matrix_mult_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [OP_W-1:0]      matrix_A,
  input  logic [OP_W-1:0]      matrix_B,
  input  logic                 start,
  output logic [RES_BUS_W-1:0] matrix_result,
  output logic [7:0]           matrix_count
);

  state_e                                state_q, state_d;
  logic [OP_W-1:0]                       a_q, a_d, b_q, b_d;
  logic [DIM*DIM-1:0][RES_W-1:0]         acc_q, acc_d;
  logic [STEP_W-1:0]                     step_q, step_d;
  logic [RES_BUS_W-1:0]                  res_int_q, res_int_d;
  logic [RES_BUS_W-1:0]                  result_q, result_d;
  logic [7:0]                            count_q, count_d;

  // Step k: element e = k>>1, term t = k&1; acc[e] += A[i][t] * B[t][j].
  logic [1:0]        elem;
  logic              term;
  logic [ELEM_W-1:0] mac_a, mac_b;
  logic [RES_W-1:0]  mac_out;

  assign elem  = step_q[STEP_W-1:1];
  assign term  = step_q[0];
  assign mac_a = get_op_elem(a_q, elem[1], term);
  assign mac_b = get_op_elem(b_q, term, elem[0]);

  matrix_mac_unit u_mac (
    .acc_in (acc_q[elem]),
    .a      (mac_a),
    .b      (mac_b),
    .acc_out(mac_out)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    step_d    = step_q;
    res_int_d = res_int_q;
    result_d  = result_q;
    count_d   = count_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        a_d     = matrix_A;
        b_d     = matrix_B;
        acc_d   = '0;
        step_d  = '0;
        state_d = MAC;
      end
      MAC: begin
        acc_d[elem] = mac_out;
        step_d      = step_q + 1'b1;
        if (step_q == STEP_W'(MAC_STEPS - 1)) state_d = STORE;
      end
      STORE: begin
        res_int_d = acc_q;
        state_d   = DONE;
      end
      DONE: begin
        result_d = res_int_q;
        count_d  = count_q + 8'd1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      step_q    <= '0;
      res_int_q <= '0;
      result_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      step_q    <= step_d;
      res_int_q <= res_int_d;
      result_q  <= result_d;
      count_q   <= count_d;
    end
  end

  assign matrix_result = result_q;
  assign matrix_count  = count_q;

endmodule

// File: tb/tb_matrix_multiplication.sv
// Scoreboarded bench: a reference model predicts each result and its edge,
// a negedge monitor checks every cycle that outputs hold or update on time.
module tb_matrix_multiplication;

  logic        clock;
  logic        reset;
  logic [15:0] matrix_A;
  logic [15:0] matrix_B;
  logic        start;
  logic [31:0] matrix_result;
  logic [7:0]  matrix_count;

  int tests_run = 0;
  int fail_cnt  = 0;

  // Entry: {due edge[71:40], result[39:8], count[7:0]}
  logic [71:0] exp_q[$];

  int          edge_n   = 0;
  int          rst_edge = -1;
  int          next_free;
  int          load_edge;
  bit          pending;
  int          launched;

  logic [31:0] hold_res;
  logic [7:0]  hold_cnt;

  matrix_multiplication dut (
    .clock        (clock),
    .reset        (reset),
    .matrix_A     (matrix_A),
    .matrix_B     (matrix_B),
    .start        (start),
    .matrix_result(matrix_result),
    .matrix_count (matrix_count)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_mult(input logic [15:0] a, input logic [15:0] b);
    int av[2][2];
    int bv[2][2];
    int c;
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        av[i][j] = int'(a[(2*i+j)*4 +: 4]);
        bv[i][j] = int'(b[(2*i+j)*4 +: 4]);
      end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        c = 0;
        for (int k = 0; k < 2; k++) c += av[i][k] * bv[k][j];
        r[(2*i+j)*8 +: 8] = 8'(c % 256);
      end
    return r;
  endfunction

  // An accepted start at edge n latches operands at n+1, publishes at n+11,
  // and the next start can be accepted from n+12.
  always @(posedge clock) begin
    edge_n = edge_n + 1;
    if (reset) begin
      rst_edge  = edge_n;
      exp_q.delete();
      pending   = 1'b0;
      launched  = 0;
      next_free = edge_n + 1;
    end else begin
      if (pending && edge_n == load_edge) begin
        exp_q.push_back({32'(load_edge + 10), ref_mult(matrix_A, matrix_B), 8'(launched)});
        pending = 1'b0;
      end
      if (start && edge_n >= next_free) begin
        launched  = launched + 1;
        load_edge = edge_n + 1;
        next_free = edge_n + 12;
        pending   = 1'b1;
      end
    end
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (act !== exp) begin
      fail_cnt = fail_cnt + 1;
      $display("FAIL %s at edge %0d: got 0x%08h expected 0x%08h", name, edge_n, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    logic [71:0] ent;
    if (edge_n > 0) begin
      if (rst_edge == edge_n) begin
        hold_res = '0;
        hold_cnt = '0;
      end
      if (exp_q.size() > 0 && int'(exp_q[0][71:40]) == edge_n) begin
        ent      = exp_q.pop_front();
        hold_res = ent[39:8];
        hold_cnt = ent[7:0];
      end
      check("sb_result", matrix_result, hold_res);
      check("sb_count", {24'd0, matrix_count}, {24'd0, hold_cnt});
    end
  end

  // ---------------- driver tasks ----------------
  // Entered at a negedge; returns at the negedge after edge 11 of the op.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold);
    matrix_A = a;
    matrix_B = b;
    start    = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (c + 1 == hold) start = 1'b0;
      if (c == 1) begin
        matrix_A = 16'($urandom);
        matrix_B = 16'($urandom);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) @(negedge clock);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    matrix_A = '0;
    matrix_B = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("reset_result", matrix_result, 32'h0);
    check("reset_count", {24'd0, matrix_count}, 32'd0);
    idle(2);

    // result must stay 0 while the first op runs
    matrix_A = 16'h4321;
    matrix_B = 16'h1234;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      check("no_early_result", matrix_result, 32'h0);
      if (c == 1) begin
        matrix_A = 16'($urandom);
        matrix_B = 16'($urandom);
      end
    end
    @(negedge clock);
    check("t2_result", matrix_result, 32'h0D140508);
    check("t2_count", {24'd0, matrix_count}, 32'd1);
    idle(3);

    run_op(16'h6543, 16'hA987, 2);
    check("t3_result", matrix_result, 32'h64594039);
    check("t3_count", {24'd0, matrix_count}, 32'd2);
    idle(14);
    check("t3_single_op", {24'd0, matrix_count}, 32'd2);

    run_op(16'hFFFF, 16'hFFFF, 1);
    check("t4_overflow", matrix_result, 32'hC2C2C2C2);
    check("t4_count", {24'd0, matrix_count}, 32'd3);

    for (int n = 0; n < 6; n++) begin
      run_op(16'($urandom), 16'($urandom), $urandom_range(1, 4));
      idle($urandom_range(0, 3));
    end

    // reset sampled at edge 5 of an op aborts it
    matrix_A = 16'($urandom);
    matrix_B = 16'($urandom);
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    idle(4);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("t5_abort_result", matrix_result, 32'h0);
    check("t5_abort_count", {24'd0, matrix_count}, 32'd0);
    idle(15);
    check("t5_no_late_result", {24'd0, matrix_count}, 32'd0);
    run_op(16'h4321, 16'h1234, 1);
    check("t5_restart_result", matrix_result, 32'h0D140508);
    check("t5_restart_count", {24'd0, matrix_count}, 32'd1);

    // 255 back-to-back ops with start held high and inputs churning
    start = 1'b1;
    for (int c = 0; c < 255 * 12; c++) begin
      matrix_A = 16'($urandom);
      matrix_B = 16'($urandom);
      @(negedge clock);
    end
    start = 1'b0;
    check("t6_wrap_count", {24'd0, matrix_count}, 32'd0);
    idle(16);
    check("t6_idle_count", {24'd0, matrix_count}, 32'd0);

    tests_run = tests_run + 1;
    if (exp_q.size() != 0) begin
      fail_cnt = fail_cnt + 1;
      $display("FAIL drain: %0d expected results never appeared, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
